// File: rtl/dds_pkg.sv
// Shared constants, lookup types and ROM-contents function for the DDS tone source.
package dds_pkg;

    localparam int unsigned PHASE_WIDTH    = 16;
    localparam int unsigned PINC           = 7;
    localparam int unsigned OUT_WIDTH      = 16;
    localparam int unsigned LUT_PHASE_BITS = 12;
    localparam int unsigned AMPL           = 32767;
    localparam int unsigned LATENCY        = 4;

    localparam int unsigned QTR_BITS  = LUT_PHASE_BITS - 2;
    localparam int unsigned ROM_DEPTH = (1 << QTR_BITS) + 1;

    typedef logic [LUT_PHASE_BITS-1:0] lut_phase_t;
    typedef logic [QTR_BITS:0]         rom_idx_t;
    typedef logic [OUT_WIDTH-2:0]      mag_t;
    typedef logic [OUT_WIDTH-1:0]      sample_t;

    typedef struct packed {
        logic     neg;
        rom_idx_t idx;
    } lut_addr_t;

    // Quadrant fold: odd quadrants read the table backwards, upper half negates.
    function automatic lut_addr_t fold_phase(lut_phase_t p);
        lut_addr_t a;
        rom_idx_t  idx;
        idx   = {1'b0, p[QTR_BITS-1:0]};
        a.neg = p[LUT_PHASE_BITS-1];
        a.idx = p[LUT_PHASE_BITS-2] ? rom_idx_t'(ROM_DEPTH - 1) - idx : idx;
        return a;
    endfunction

    // round(AMPL * sin(pi/2 * i / 1024)); Taylor series to x^19 keeps the
    // error far below half an LSB over the first quadrant.
    function automatic mag_t quarter_sine(int unsigned i);
        real x;
        real term;
        real acc;
        x    = 1.5707963267948966 * real'(i) / real'(ROM_DEPTH - 1);
        term = x;
        acc  = x;
        for (int unsigned n = 1; n < 10; n++) begin
            term = -term * x * x / (real'(2 * n) * real'(2 * n + 1));
            acc  = acc + term;
        end
        return mag_t'($rtoi(real'(AMPL) * acc + 0.5));
    endfunction

endpackage

// File: rtl/dds_quarter_lut.sv
// Dual-read quarter-wave sine ROM: fold (stage 2), read (stage 3), negate (stage 4).
module dds_quarter_lut
    import dds_pkg::*;
(
    input  logic                      clk_i,
    input  logic                      rst_ni,
    input  logic [LUT_PHASE_BITS-1:0] phase_i,
    output logic [OUT_WIDTH-1:0]      sin_o,
    output logic [OUT_WIDTH-1:0]      cos_o
);

    mag_t rom_w [ROM_DEPTH];

    for (genvar g = 0; g < ROM_DEPTH; g++) begin : g_rom
        localparam mag_t V = quarter_sine(g);
        assign rom_w[g] = V;
    end

    lut_addr_t sin_addr_q, cos_addr_q;
    mag_t      sin_mag_q, cos_mag_q;
    logic      sin_neg_q, cos_neg_q;
    sample_t   sin_q, cos_q;

    // Stage 2: quadrant/index decode; cos is sin advanced by a quarter turn.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            sin_addr_q <= '0;
            cos_addr_q <= '0;
        end else begin
            sin_addr_q <= fold_phase(phase_i);
            cos_addr_q <= fold_phase(phase_i + lut_phase_t'(1 << QTR_BITS));
        end
    end

    // Stage 3: ROM read, sign flag carried alongside.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            sin_mag_q <= '0;
            cos_mag_q <= '0;
            sin_neg_q <= 1'b0;
            cos_neg_q <= 1'b0;
        end else begin
            sin_mag_q <= rom_w[sin_addr_q.idx];
            cos_mag_q <= rom_w[cos_addr_q.idx];
            sin_neg_q <= sin_addr_q.neg;
            cos_neg_q <= cos_addr_q.neg;
        end
    end

    // Stage 4: apply sign; magnitude tops out at AMPL so -32768 cannot occur.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            sin_q <= '0;
            cos_q <= '0;
        end else begin
            sin_q <= sin_neg_q ? -sample_t'(sin_mag_q) : sample_t'(sin_mag_q);
            cos_q <= cos_neg_q ? -sample_t'(cos_mag_q) : sample_t'(cos_mag_q);
        end
    end

    assign sin_o = sin_q;
    assign cos_o = cos_q;

endmodule

// File: rtl/dds_compiler.sv
// Free-running quadrature test tone on an AXI4-Stream master (no tready).
module dds_compiler
    import dds_pkg::*;
(
    input  logic        aclk,
    input  logic        aresetn,
    output logic        m_axis_data_tvalid,
    output logic [31:0] m_axis_data_tdata
);

    logic [PHASE_WIDTH-1:0] phase_q, phase_d;
    logic [LATENCY-1:0]     valid_q, valid_d;
    sample_t                sin_w, cos_w;

    // Accumulator holds 0 through edge 1 so phase 0 enters the LUT at edge 2,
    // giving sample 0 out exactly after edge 4.
    always_comb begin
        phase_d = '0;
        if (valid_q[0]) begin
            phase_d = phase_q + PHASE_WIDTH'(PINC);
        end
        valid_d = {valid_q[LATENCY-2:0], 1'b1};
    end

    // Stage 1 accumulator and pipeline-fill tracker.
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            phase_q <= '0;
            valid_q <= '0;
        end else begin
            phase_q <= phase_d;
            valid_q <= valid_d;
        end
    end

    dds_quarter_lut u_lut (
        .clk_i   (aclk),
        .rst_ni  (aresetn),
        .phase_i (phase_q[PHASE_WIDTH-1 -: LUT_PHASE_BITS]),
        .sin_o   (sin_w),
        .cos_o   (cos_w)
    );

    assign m_axis_data_tvalid = valid_q[LATENCY-1];
    assign m_axis_data_tdata  = {sin_w, cos_w};

endmodule

// File: tb/tb_dds_compiler.sv
// Directed bench for dds_compiler: reset, latency, key phases, long stream, mid-stream reset.
module tb_dds_compiler;

    logic        aclk;
    logic        aresetn;
    logic        m_axis_data_tvalid;
    logic [31:0] m_axis_data_tdata;

    int n_cmp = 0;
    int n_err = 0;

    dds_compiler dut (
        .aclk               (aclk),
        .aresetn            (aresetn),
        .m_axis_data_tvalid (m_axis_data_tvalid),
        .m_axis_data_tdata  (m_axis_data_tdata)
    );

    initial aclk = 1'b0;
    always #5 aclk = ~aclk;

    task automatic check(input string tag, input longint got, input longint exp, input longint tol);
        n_cmp++;
        if (got > exp + tol || got < exp - tol) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d (tol %0d) at %0t", tag, got, exp, tol, $time);
        end
    endtask

    function automatic longint rnd(real x);
        if (x >= 0.0) return longint'($rtoi(x + 0.5));
        return -longint'($rtoi(-x + 0.5));
    endfunction

    // Independent model: P = (k*7 mod 65536) >> 4, angle offset in quarter turns.
    function automatic longint model(int k, int quarter);
        int  ph;
        int  p;
        real ang;
        ph  = (k * 7) % 65536;
        p   = ((ph >> 4) + quarter * 1024) % 4096;
        ang = 6.283185307179586 * real'(p) / 4096.0;
        return rnd(32767.0 * $sin(ang));
    endfunction

    task automatic check_beat(input int k);
        longint s, c;
        s = longint'($signed(m_axis_data_tdata[31:16]));
        c = longint'($signed(m_axis_data_tdata[15:0]));
        check("tvalid", longint'(m_axis_data_tvalid), 1, 0);
        check("sin", s, model(k, 0), 1);
        check("cos", c, model(k, 1), 1);
        check("sin_not_min", longint'(s == -32768), 0, 0);
        check("cos_not_min", longint'(c == -32768), 0, 0);
        check("sumsq", s * s + c * c, 64'd1073676289, 65534);
    endtask

    initial begin
        longint prev_s, cur_s;
        int     last_cross;

        aresetn = 1'b0;
        // Reset held for 10 cycles: outputs quiet throughout.
        for (int i = 0; i < 10; i++) begin
            @(posedge aclk); #1;
            check("rst_tvalid", longint'(m_axis_data_tvalid), 0, 0);
            check("rst_tdata", longint'(m_axis_data_tdata), 0, 0);
        end

        @(negedge aclk); aresetn = 1'b1;
        for (int e = 1; e <= 3; e++) begin
            @(posedge aclk); #1;
            check("fill_tvalid", longint'(m_axis_data_tvalid), 0, 0);
        end
        @(posedge aclk); #1;
        check("first_tvalid", longint'(m_axis_data_tvalid), 1, 0);
        check("first_tdata", longint'(m_axis_data_tdata), 64'h0000_7FFF, 0);
        check_beat(0);

        prev_s     = longint'($signed(m_axis_data_tdata[31:16]));
        last_cross = -1;
        for (int k = 1; k < 20000; k++) begin
            @(posedge aclk); #1;
            check_beat(k);
            if (k == 2341) check("k2341_p1024", longint'(m_axis_data_tdata), 64'h7FFF_0000, 0);
            if (k == 4682) check("k4682_p2048", longint'(m_axis_data_tdata), 64'h0000_8001, 0);
            if (k == 7023) check("k7023_p3072", longint'(m_axis_data_tdata), 64'h8001_0000, 0);
            if (k == 9363) check("k9363_wrap", longint'(m_axis_data_tdata), 64'h0000_7FFF, 0);
            cur_s = longint'($signed(m_axis_data_tdata[31:16]));
            if (prev_s < 0 && cur_s >= 0) begin
                if (last_cross >= 0) check("zc_spacing", longint'(k - last_cross), 9362, 1);
                else check("zc_first", longint'(k), 9363, 0);
                last_cross = k;
            end
            prev_s = cur_s;
        end
        check("zc_seen_twice", longint'(last_cross), 18725, 0);

        // Asynchronous reset between edges: outputs clear before the next edge.
        @(posedge aclk); #3;
        aresetn = 1'b0;
        #1;
        check("async_tvalid", longint'(m_axis_data_tvalid), 0, 0);
        check("async_tdata", longint'(m_axis_data_tdata), 0, 0);
        for (int i = 0; i < 3; i++) begin
            @(posedge aclk); #1;
            check("rst2_tvalid", longint'(m_axis_data_tvalid), 0, 0);
            check("rst2_tdata", longint'(m_axis_data_tdata), 0, 0);
        end
        #2 aresetn = 1'b1;
        for (int e = 1; e <= 3; e++) begin
            @(posedge aclk); #1;
            check("refill_tvalid", longint'(m_axis_data_tvalid), 0, 0);
        end
        @(posedge aclk); #1;
        check("restart_tdata", longint'(m_axis_data_tdata), 64'h0000_7FFF, 0);
        check_beat(0);
        for (int k = 1; k < 64; k++) begin
            @(posedge aclk); #1;
            check_beat(k);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
